// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC credit-link receiver.
// Default flit/dest widths, packed flit record, count-width helper.
package noc_pkg;

  localparam int FLIT_WIDTH_DEF = 128;
  localparam int DEST_WIDTH_DEF = 8;

  typedef struct packed {
    logic [FLIT_WIDTH_DEF-1:0] data;
    logic [DEST_WIDTH_DEF-1:0] dest;
    logic                      is_tail;
  } flit_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// FWFT flit buffer: storage, wrapping pointers and occupancy count.
// Ports: clk, rst_n, push/push_data, pop/pop_data, full, empty.
module noc_rx_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FLIT_WIDTH_DEF + DEST_WIDTH_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full buffer still lands if a slot frees this cycle.
  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | do_rd);

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= nxt(wr_ptr);
      if (do_rd) rd_ptr <= nxt(rd_ptr);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_credit_receiver.sv
// Credit-link receiver: buffers flits, FWFT output, one credit per dequeue.
// Optional sticky overflow_err when NOC_CREDIT_RX_OVERFLOW_CHECK_EN is defined.
module noc_credit_receiver
  import noc_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4,
  parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
  parameter int DEST_WIDTH   = DEST_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  overflow_err
);

  localparam int W = FLIT_WIDTH + DEST_WIDTH + 1;

  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         full;
  logic         empty;
  logic         deq;

  assign wdata = {data_in, dest_in, is_tail_in};
  assign {data_out, dest_out, is_tail_out} = rdata;

  noc_rx_fifo #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (send_in),
    .push_data (wdata),
    .pop       (ready_in),
    .pop_data  (rdata),
    .full      (full),
    .empty     (empty)
  );

  assign valid_out = ~empty;
  assign deq       = valid_out & ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_out <= 1'b0;
    else        credit_out <= deq;
  end

`ifdef NOC_CREDIT_RX_OVERFLOW_CHECK_EN
  logic drop;
  logic ovf_q;

  assign drop = send_in & full & ~deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign overflow_err = ovf_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!drop)
        else $warning("noc_credit_receiver: flit dropped on full buffer");
    end
  end
`endif
`else
  logic unused_full;
  assign unused_full  = full;
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_receiver.sv
// Self-checking bench for noc_credit_receiver against a queue model.
// Directed phases plus randomized traffic; DEPTH selects buffer size.
module tb_noc_credit_receiver #(
  parameter int DEPTH = 4
);
  import noc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data_in = '0;
  logic [7:0]   dest_in = '0;
  logic         is_tail_in = 1'b0;
  logic         send_in = 1'b0;
  logic         ready_in = 1'b0;
  logic         credit_out;
  logic [127:0] data_out;
  logic [7:0]   dest_out;
  logic         is_tail_out;
  logic         valid_out;
  logic         overflow_err;

  int tests = 0;
  int fails = 0;
  int cred_seen = 0;
  int valid_seen = 0;

  flit_t mq[$];
  logic  m_cred = 1'b0;
  logic  m_ovf = 1'b0;

  noc_credit_receiver #(
    .BUFFER_DEPTH (DEPTH),
    .FLIT_WIDTH   (128),
    .DEST_WIDTH   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .is_tail_out  (is_tail_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 128'(valid_out), 128'(mq.size() != 0));
    check({tag, ".credit"}, 128'(credit_out), 128'(m_cred));
    check({tag, ".ovf"}, 128'(overflow_err), 128'(m_ovf));
    if (mq.size() != 0) begin
      check({tag, ".data"}, data_out, mq[0].data);
      check({tag, ".dest"}, 128'(dest_out), 128'(mq[0].dest));
      check({tag, ".tail"}, 128'(is_tail_out), 128'(mq[0].is_tail));
    end
  endtask

  // One clock: drive, let the model apply the protocol rules, compare.
  task automatic cycle(input string tag, input logic s,
                       input logic [127:0] d, input logic [7:0] de,
                       input logic t, input logic r);
    bit deq;
    bit enq;
    flit_t f;
    send_in    = s;
    data_in    = d;
    dest_in    = de;
    is_tail_in = t;
    ready_in   = r;
    @(posedge clk);
    deq = (mq.size() != 0) && r;
    enq = s && ((mq.size() < DEPTH) || deq);
    m_cred = deq;
`ifdef NOC_CREDIT_RX_OVERFLOW_CHECK_EN
    if (s && !enq) m_ovf = 1'b1;
`endif
    if (deq) void'(mq.pop_front());
    if (enq) begin
      f.data    = d;
      f.dest    = de;
      f.is_tail = t;
      mq.push_back(f);
    end
    #1;
    check_outputs(tag);
    if (credit_out === 1'b1) cred_seen++;
    if (valid_out === 1'b1) valid_seen++;
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst.valid", 128'(valid_out), 128'(0));
    check("rst.credit", 128'(credit_out), 128'(0));
    check("rst.ovf", 128'(overflow_err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with consumer stalled: head must hold the first flit.
    for (int i = 1; i <= DEPTH; i++)
      cycle("fill", 1'b1, 128'(i), 8'(i), 1'b0, 1'b0);
    check("fill.head", data_out, 128'(1));

    // Drain in order, then one idle cycle for the last credit.
    cred_seen = 0;
    for (int i = 0; i < DEPTH; i++)
      cycle("drain", 1'b0, '0, '0, 1'b0, 1'b1);
    cycle("drain.idle", 1'b0, '0, '0, 1'b0, 1'b0);
    check("drain.credits", 128'(cred_seen), 128'(DEPTH));

    // Full + simultaneous send/deq, then a dropped send.
    for (int i = 1; i <= DEPTH; i++)
      cycle("refill", 1'b1, 128'(16 + i), 8'(i), 1'b0, 1'b0);
    cycle("full.sendeq", 1'b1, 128'h55, 8'h55, 1'b1, 1'b1);
    cycle("full.hold", 1'b0, '0, '0, 1'b0, 1'b0);
    cycle("full.drop", 1'b1, 128'h66, 8'h66, 1'b0, 1'b0);
    cycle("full.after", 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef NOC_CREDIT_RX_OVERFLOW_CHECK_EN
    check("drop.ovf_set", 128'(overflow_err), 128'(1));
`else
    check("drop.ovf_tied", 128'(overflow_err), 128'(0));
`endif
    for (int i = 0; i < DEPTH; i++)
      cycle("drain2", 1'b0, '0, '0, 1'b0, 1'b1);
    cycle("drain2.idle", 1'b0, '0, '0, 1'b0, 1'b0);
    cycle("drain2.idle2", 1'b0, '0, '0, 1'b0, 1'b0);

    // Streaming: 20 flits, one per cycle, tail on every fifth.
    cred_seen  = 0;
    valid_seen = 0;
    for (int i = 0; i < 20; i++)
      cycle("stream", 1'b1, 128'({$urandom, $urandom}), 8'(i),
            (i % 5) == 4, 1'b1);
    cycle("stream.end", 1'b0, '0, '0, 1'b0, 1'b1);
    cycle("stream.idle", 1'b0, '0, '0, 1'b0, 1'b0);
    check("stream.credits", 128'(cred_seen), 128'(20));
    check("stream.valid_cycles", 128'(valid_seen), 128'(20));

    // Random traffic, including drops and empty-buffer reads.
    for (int i = 0; i < 300; i++)
      cycle("rand", $urandom_range(3, 0) != 0,
            {$urandom, $urandom, $urandom, $urandom},
            8'($urandom), 1'($urandom), 1'($urandom));

    // Drain, then rebuild 3 flits with a credit pending.
    for (int i = 0; i < DEPTH + 1; i++)
      cycle("pre_rst", 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle("pre_rst.fill", 1'b1, 128'(32 + i), 8'(i), 1'b0, 1'b0);
    cycle("pre_rst.deq", 1'b1, 128'h40, 8'h40, 1'b0, 1'b1);

    // Asynchronous reset away from the clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_cred = 1'b0;
    m_ovf  = 1'b0;
    check("arst.valid", 128'(valid_out), 128'(0));
    check("arst.credit", 128'(credit_out), 128'(0));
    check("arst.ovf", 128'(overflow_err), 128'(0));
    send_in  = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 128'hABCD, 8'h7, 1'b1, 1'b0);
    check("post_rst.data", data_out, 128'hABCD);
    cycle("post_rst.deq", 1'b0, '0, '0, 1'b0, 1'b1);
    cycle("post_rst.idle", 1'b0, '0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
